// File: rtl/imem_responder_if.sv
// Bus bundle between the instruction-memory responder and its loader / fetch initiator.
// Load handshake: a word moves only on a clock edge where load_valid and load_ready are both high; load_data holds while load_valid waits.
interface imem_responder_if #(
   parameter int MEM_WIDTH = 32,
   parameter int AW        = 8
);
   logic [AW-1:0]        mem_addr;
   logic                 mem_read_en;
   logic [MEM_WIDTH-1:0] mem_read_val;
   logic                 mem_read_valid;
   logic                 read_err;
   logic                 load_start;
   logic [AW:0]          load_len;
   logic [MEM_WIDTH-1:0] load_data;
   logic                 load_valid;
   logic                 load_ready;
   logic                 load_done;
   logic                 ready;

   modport master (
      output mem_addr, mem_read_en, load_start, load_len, load_data, load_valid,
      input  mem_read_val, mem_read_valid, read_err, load_ready, load_done, ready
   );

   modport slave (
      input  mem_addr, mem_read_en, load_start, load_len, load_data, load_valid,
      output mem_read_val, mem_read_valid, read_err, load_ready, load_done, ready
   );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory that is first filled through a load stream, then serves
// single-cycle-latency reads of the loaded range.
module imem_responder #(
   parameter int MEM_WIDTH = 32,
   parameter int MEM_SIZE  = 256
) (
   input  logic                clk,
   input  logic                rst,
   imem_responder_if.slave     bus,
   output logic [1:0]          o_dbg_state
);
   localparam int AW = $clog2(MEM_SIZE);
   localparam logic [AW:0] SIZE_W = (AW+1)'(MEM_SIZE);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_LOAD  = 2'd1,
      S_READY = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [MEM_WIDTH-1:0] r_mem [MEM_SIZE];
   logic [AW:0]          r_wr_ptr;
   logic [AW:0]          r_len;
   logic [AW:0]          r_loaded_len;
   logic [MEM_WIDTH-1:0] r_rd_val;
   logic                 r_rd_valid;
   logic                 r_rd_err;
   logic                 r_load_done;
   logic                 w_start_ok;
   logic                 w_accept;
   logic                 w_last;
   logic                 w_rd_ok;
   logic [AW:0]          w_len_clip;

   always_comb begin
      w_state_nxt = r_state;
      w_start_ok  = 1'b0;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      w_len_clip  = (bus.load_len > SIZE_W) ? SIZE_W : bus.load_len;
      // Reads use the current state, so a read issued alongside a new load_start is still serviced.
      w_rd_ok     = bus.mem_read_en && (r_state == S_READY) &&
                    ({1'b0, bus.mem_addr} < r_loaded_len);
      case (r_state)
         S_EMPTY, S_READY: begin
            if (bus.load_start && (bus.load_len != '0)) begin
               w_start_ok  = 1'b1;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (bus.load_valid) begin
               w_accept = 1'b1;
               if (r_wr_ptr == (r_len - 1'b1)) begin
                  w_last      = 1'b1;
                  w_state_nxt = S_READY;
               end
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_EMPTY;
         r_wr_ptr     <= '0;
         r_len        <= '0;
         r_loaded_len <= '0;
         r_rd_val     <= '0;
         r_rd_valid   <= 1'b0;
         r_rd_err     <= 1'b0;
         r_load_done  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rd_valid  <= w_rd_ok;
         r_rd_err    <= bus.mem_read_en && !w_rd_ok;
         r_rd_val    <= w_rd_ok ? r_mem[bus.mem_addr] : '0;
         r_load_done <= w_last;
         if (w_start_ok) begin
            r_wr_ptr <= '0;
            r_len    <= w_len_clip;
         end else if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_last) r_loaded_len <= r_len;
      end
   end

   // The array itself is never reset; loaded_len gates what is readable.
   always_ff @(posedge clk) begin
      if (!rst && w_accept) r_mem[r_wr_ptr[AW-1:0]] <= bus.load_data;
   end

   assign bus.mem_read_val   = r_rd_val;
   assign bus.mem_read_valid = r_rd_valid;
   assign bus.read_err       = r_rd_err;
   assign bus.load_done      = r_load_done;
   assign bus.load_ready     = (r_state == S_LOAD);
   assign bus.ready          = (r_state == S_READY);
   assign o_dbg_state        = r_state;
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The module SHALL have parameter MEM_WIDTH, default 32, word width in bits.
REQ-002 The module SHALL have parameter MEM_SIZE, default 256, depth in words; AW = $clog2(MEM_SIZE).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-005 The module SHALL have port mem_addr, input, AW bits, read word address from the fetch initiator.
REQ-006 The module SHALL have port mem_read_en, input, 1 bit, read request strobe.
REQ-007 The module SHALL have port mem_read_val, output, MEM_WIDTH bits, registered read data.
REQ-008 The module SHALL have port mem_read_valid, output, 1 bit, high when mem_read_val carries good data.
REQ-009 The module SHALL have port read_err, output, 1 bit, one-cycle pulse for a rejected read.
REQ-010 The module SHALL have port load_start, input, 1 bit, begin program load.
REQ-011 The module SHALL have port load_len, input, AW+1 bits, word count to load, sampled with load_start.
REQ-012 The module SHALL have port load_data, input, MEM_WIDTH bits, program word.
REQ-013 The module SHALL have port load_valid, input, 1 bit, load_data is valid.
REQ-014 The module SHALL have port load_ready, output, 1 bit, the module accepts load_data.
REQ-015 The module SHALL have port load_done, output, 1 bit, one-cycle pulse at load completion.
REQ-016 The module SHALL have port ready, output, 1 bit, high while the module is in state READY.

Function
REQ-017 The module SHALL implement states EMPTY, LOAD and READY.
REQ-018 EMPTY or READY with load_start=1 and load_len!=0 SHALL go to LOAD, clearing wr_ptr to 0 and latching len = min(load_len, MEM_SIZE).
REQ-019 load_start with load_len=0 SHALL be ignored, and the state SHALL be unchanged.
REQ-020 load_start while in LOAD SHALL be ignored.
REQ-021 load_ready SHALL equal 1 only in LOAD.
REQ-022 A word SHALL be accepted only on a cycle with load_valid=1 and load_ready=1; the module SHALL then write mem[wr_ptr]=load_data and increment wr_ptr.
REQ-023 Acceptance of word len-1 SHALL move the state to LOAD→READY, store loaded_len=len, and pulse load_done on the next cycle.
REQ-024 When load_valid=0 in LOAD, the module SHALL hold wr_ptr with no timeout.
REQ-025 A read with mem_read_en=1 at cycle N, in READY, and mem_addr<loaded_len SHALL produce mem_read_val=mem[mem_addr] and mem_read_valid=1 at cycle N+1 (1-cycle latency).
REQ-026 Back-to-back reads SHALL be sustained at one per cycle.
REQ-027 A read with mem_read_en=1 while not in READY, or with mem_addr>=loaded_len, SHALL produce read_err=1, mem_read_valid=0 and mem_read_val=0 at N+1.
REQ-028 A cycle following mem_read_en=0 SHALL produce mem_read_valid=0 and mem_read_val=0.
REQ-029 A load_start accepted in READY SHALL force ready=0 from the next cycle; a read issued in that same cycle SHALL still be serviced.
REQ-030 The module SHALL NOT allow a write and a read to overlap, because writes occur only in LOAD and reads only in READY.

Reset
REQ-031 rst=1 SHALL force state EMPTY, wr_ptr=0, loaded_len=0, mem_read_val=0, mem_read_valid=0, read_err=0, load_ready=0, load_done=0 and ready=0.
REQ-032 Reset SHALL NOT clear the array contents; all locations SHALL remain unreadable until a new load completes.
REQ-033 rst asserted mid-load SHALL abort the load, with no load_done pulse.
REQ-034 rst SHALL have priority over every simultaneous load_start, load_valid or mem_read_en.

Verification
REQ-035 Load 4 words 0x11,0x22,0x33,0x44 with load_valid continuous -> load_done pulses 1 cycle after the 4th accept, and ready=1.
REQ-036 After REQ-035, reads at addr 0,1,2,3 on consecutive cycles -> mem_read_val is 0x11,0x22,0x33,0x44 on the following cycles with mem_read_valid=1 each cycle.
REQ-037 After REQ-035, read addr 4 -> read_err=1, mem_read_val=0 and mem_read_valid=0 next cycle.
REQ-038 Read while EMPTY and read while LOAD -> read_err pulse each time, and no valid.
REQ-039 load_len=300 with MEM_SIZE=256 -> exactly 256 accepts, then load_done; read addr 255 returns the last word.
REQ-040 rst after 2 of 4 words accepted -> no load_done, state EMPTY; a subsequent read -> read_err; reload with load_len=1 of 0xAB -> read addr 0 returns 0xAB.
